// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch front end: pipelined Wishbone reads into an in-order FIFO,
// with redirect flush, squashing of in-flight responses and bus-error tagging.
module fetch_prefetch_queue #(
    parameter logic [31:0] INIT_PC         = 32'h1000_0000,
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic [31:0] o_wb_adr,
    input  logic        i_wb_stall,
    input  logic        i_wb_ack,
    input  logic        i_wb_err,
    input  logic [31:0] i_wb_dat,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic        o_err,
    input  logic        i_ready,
    output logic        o_idle
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] dat;
        logic        err;
    } entry_t;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   ret_pc_q, ret_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] squash_q, squash_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic          halted_q, halted_d;
    entry_t        mem_q [DEPTH];

    entry_t        head;
    entry_t        push_entry;
    logic [31:0]   redirect_pc;
    logic [31:0]   occupancy;
    logic          stb, accept, resp, drop, keep, pop, push, pop_en;

    // Words already buffered, requested, or still to be discarded all reserve a FIFO slot.
    assign redirect_pc = i_redirect_pc & 32'hFFFF_FFFC;
    assign occupancy   = 32'(count_q) + 32'(outstanding_q) + 32'(squash_q);
    assign stb         = i_rst_n & ~halted_q & (32'(outstanding_q) < MAX_OUTSTANDING)
                         & (occupancy < DEPTH);
    assign accept      = stb & ~i_wb_stall;
    assign resp        = i_wb_ack | i_wb_err;
    assign drop        = resp & (squash_q != '0);
    assign keep        = resp & (squash_q == '0);
    assign pop         = (count_q != '0) & i_ready;
    assign push_entry  = '{pc: ret_pc_q, dat: i_wb_dat, err: i_wb_err};

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        ret_pc_d      = ret_pc_q;
        count_d       = count_q;
        outstanding_d = outstanding_q + CW'(accept) - CW'(keep);
        squash_d      = squash_q - CW'(drop);
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        halted_d      = halted_q | (keep & i_wb_err);
        push          = keep;
        pop_en        = pop;

        if (accept) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (keep) begin
            ret_pc_d = ret_pc_q + 32'd4;
        end

        // Redirect wins: every read still on the bus becomes a response to discard.
        if (i_redirect) begin
            fetch_pc_d    = redirect_pc;
            ret_pc_d      = redirect_pc;
            outstanding_d = '0;
            squash_d      = squash_q + outstanding_q + CW'(accept) - CW'(resp);
            halted_d      = 1'b0;
            push          = 1'b0;
            pop_en        = 1'b0;
            count_d       = '0;
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
        end else begin
            count_d  = count_q + CW'(push) - CW'(pop_en);
            wr_ptr_d = wr_ptr_q + AW'(push);
            rd_ptr_d = rd_ptr_q + AW'(pop_en);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fetch_pc_q    <= INIT_PC;
            ret_pc_q      <= INIT_PC;
            count_q       <= '0;
            outstanding_q <= '0;
            squash_q      <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            halted_q      <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            ret_pc_q      <= ret_pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            squash_q      <= squash_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            halted_q      <= halted_d;
        end
    end

    // Payload storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    assign head     = mem_q[rd_ptr_q];
    assign o_wb_stb = stb;
    assign o_wb_adr = fetch_pc_q;
    assign o_wb_cyc = stb | (outstanding_q != '0) | (squash_q != '0);
    assign o_valid  = (count_q != '0);
    assign o_err    = o_valid & head.err;
    assign o_instr  = o_err ? 32'h0000_0013 : head.dat;
    assign o_pc     = head.pc;
    assign o_idle   = (outstanding_q == '0) & (squash_q == '0);

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue: in-order Wishbone responder model plus
// per-scenario tasks with hand-derived expected PCs and words.
module tb_fetch_prefetch_queue;

    localparam logic [31:0] INIT = 32'h1000_0000;

    logic        clk;
    logic        rst_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        wb_cyc, wb_stb, wb_stall, wb_ack, wb_err;
    logic [31:0] wb_adr, wb_dat;
    logic        valid, err, ready, idle;
    logic [31:0] instr, pc;

    int tests_run    = 0;
    int tests_failed = 0;

    bit          resp_en;
    bit          stall_rand;
    int          err_at;
    int          resp_idx;
    int          acc_cnt;
    logic [31:0] req_q [$];
    logic [31:0] bus_a;

    fetch_prefetch_queue dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_redirect(redirect), .i_redirect_pc(redirect_pc),
        .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_adr(wb_adr),
        .i_wb_stall(wb_stall), .i_wb_ack(wb_ack), .i_wb_err(wb_err), .i_wb_dat(wb_dat),
        .o_valid(valid), .o_instr(instr), .o_pc(pc), .o_err(err),
        .i_ready(ready), .o_idle(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] dat_of(input logic [31:0] a);
        return a ^ 32'h5A5A_F00F;
    endfunction

    // Bus responder: accepted reads are answered one per cycle, in order, starting the next cycle.
    initial begin
        wb_ack = 1'b0; wb_err = 1'b0; wb_stall = 1'b0; wb_dat = '0;
        resp_idx = 0; acc_cnt = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                req_q.delete();
                wb_ack = 1'b0; wb_err = 1'b0; wb_stall = 1'b0;
                resp_idx = 0; acc_cnt = 0;
            end else begin
                if (wb_stb && !wb_stall) begin
                    req_q.push_back(wb_adr);
                    acc_cnt++;
                end
                #1;
                wb_ack = 1'b0; wb_err = 1'b0;
                if (resp_en && req_q.size() != 0) begin
                    bus_a  = req_q.pop_front();
                    wb_dat = dat_of(bus_a);
                    if (resp_idx == err_at) wb_err = 1'b1;
                    else                    wb_ack = 1'b1;
                    resp_idx++;
                end
                wb_stall = stall_rand ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic wait_pop(output logic [31:0] p, output logic [31:0] ins,
                            output logic e, output logic ok);
        ok = 1'b0; p = '0; ins = '0; e = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (valid && ready) begin
                p = pc; ins = instr; e = err; ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests_run++;
        if ({wb_cyc, wb_stb, valid, err, idle} !== 5'b00001) begin
            tests_failed++;
            $display("FAIL reset: got cyc/stb/valid/err/idle=%b want 00001",
                     {wb_cyc, wb_stb, valid, err, idle});
        end
    endtask

    task automatic test_stream();
        logic [31:0] e;
        ready = 1'b1; resp_en = 1'b1; stall_rand = 1'b0; err_at = -1;
        apply_reset();
        tests_run++;
        if ({wb_stb, wb_adr, valid} !== {1'b1, INIT, 1'b0}) begin
            tests_failed++;
            $display("FAIL stream_first_stb: got stb=%b adr=%h valid=%b want 1 %h 0",
                     wb_stb, wb_adr, valid, INIT);
        end
        @(negedge clk);
        tests_run++;
        if (valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL stream_latency: got valid=%b one cycle after stb, want 0", valid);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            e = INIT + 32'(4 * k);
            tests_run++;
            if ({valid, pc, instr} !== {1'b1, e, dat_of(e)}) begin
                tests_failed++;
                $display("FAIL stream[%0d]: got valid=%b pc=%h instr=%h want 1 %h %h",
                         k, valid, pc, instr, e, dat_of(e));
            end
        end
    endtask

    task automatic test_full();
        logic [31:0] e;
        ready = 1'b0; resp_en = 1'b1; stall_rand = 1'b0; err_at = -1;
        apply_reset();
        repeat (10) @(negedge clk);
        tests_run++;
        if ({acc_cnt == 4, wb_stb, valid, pc} !== {1'b1, 1'b0, 1'b1, INIT}) begin
            tests_failed++;
            $display("FAIL full: got accepts=%0d stb=%b valid=%b pc=%h want 4 0 1 %h",
                     acc_cnt, wb_stb, valid, pc, INIT);
        end
        @(posedge clk); #2;
        ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            e = INIT + 32'(4 * k);
            tests_run++;
            if ({valid, pc, instr} !== {1'b1, e, dat_of(e)}) begin
                tests_failed++;
                $display("FAIL full_drain[%0d]: got valid=%b pc=%h instr=%h want 1 %h %h",
                         k, valid, pc, instr, e, dat_of(e));
            end
        end
    endtask

    task automatic test_redirect();
        logic [31:0] p, ins, e;
        logic        er, ok;
        ready = 1'b0; resp_en = 1'b0; stall_rand = 1'b0; err_at = -1;
        apply_reset();
        repeat (4) @(negedge clk);
        tests_run++;
        if ({acc_cnt == 2, wb_stb, idle} !== 3'b100) begin
            tests_failed++;
            $display("FAIL redirect_pre: got accepts=%0d stb=%b idle=%b want 2 0 0",
                     acc_cnt, wb_stb, idle);
        end
        @(posedge clk); #2;
        redirect = 1'b1; redirect_pc = 32'h2000_0002;
        @(posedge clk); #2;
        redirect = 1'b0; resp_en = 1'b1; ready = 1'b1;
        tests_run++;
        if ({wb_stb, wb_adr} !== {1'b1, 32'h2000_0000}) begin
            tests_failed++;
            $display("FAIL redirect_stb: got stb=%b adr=%h want 1 20000000", wb_stb, wb_adr);
        end
        for (int k = 0; k < 3; k++) begin
            wait_pop(p, ins, er, ok);
            e = 32'h2000_0000 + 32'(4 * k);
            tests_run++;
            if ({ok, p, ins, er} !== {1'b1, e, dat_of(e), 1'b0}) begin
                tests_failed++;
                $display("FAIL redirect_pop[%0d]: got ok=%b pc=%h instr=%h err=%b want 1 %h %h 0",
                         k, ok, p, ins, er, e, dat_of(e));
            end
        end
    endtask

    task automatic test_error();
        logic [31:0] p, ins, e, ei;
        logic        er, ok, ee;
        ready = 1'b0; resp_en = 1'b1; stall_rand = 1'b0; err_at = 1;
        apply_reset();
        repeat (8) @(negedge clk);
        tests_run++;
        if ({acc_cnt == 3, wb_stb} !== 2'b10) begin
            tests_failed++;
            $display("FAIL error_halt: got accepts=%0d stb=%b want 3 0", acc_cnt, wb_stb);
        end
        @(posedge clk); #2;
        ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_pop(p, ins, er, ok);
            e  = INIT + 32'(4 * k);
            ee = (k == 1);
            ei = ee ? 32'h0000_0013 : dat_of(e);
            tests_run++;
            if ({ok, p, ins, er} !== {1'b1, e, ei, ee}) begin
                tests_failed++;
                $display("FAIL error_pop[%0d]: got ok=%b pc=%h instr=%h err=%b want 1 %h %h %b",
                         k, ok, p, ins, er, e, ei, ee);
            end
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if ({wb_stb, valid} !== 2'b00) begin
            tests_failed++;
            $display("FAIL error_stay_halted: got stb=%b valid=%b want 0 0", wb_stb, valid);
        end
        err_at = -1;
        @(posedge clk); #2;
        redirect = 1'b1; redirect_pc = 32'h3000_0000;
        @(posedge clk); #2;
        redirect = 1'b0;
        tests_run++;
        if ({wb_stb, wb_adr} !== {1'b1, 32'h3000_0000}) begin
            tests_failed++;
            $display("FAIL error_restart_stb: got stb=%b adr=%h want 1 30000000", wb_stb, wb_adr);
        end
        wait_pop(p, ins, er, ok);
        tests_run++;
        if ({ok, p, ins, er} !== {1'b1, 32'h3000_0000, dat_of(32'h3000_0000), 1'b0}) begin
            tests_failed++;
            $display("FAIL error_restart_pop: got ok=%b pc=%h instr=%h err=%b want 1 30000000 %h 0",
                     ok, p, ins, er, dat_of(32'h3000_0000));
        end
    endtask

    task automatic test_random();
        logic [31:0] e;
        int          pops;
        ready = 1'b1; resp_en = 1'b1; stall_rand = 1'b1; err_at = -1;
        apply_reset();
        e = INIT; pops = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clk);
            if (redirect) begin
                e = redirect_pc & 32'hFFFF_FFFC;
            end else if (valid && ready) begin
                pops++;
                tests_run++;
                if ({pc, instr, err} !== {e, dat_of(e), 1'b0}) begin
                    tests_failed++;
                    $display("FAIL random_pop[%0d]: got pc=%h instr=%h err=%b want %h %h 0",
                             cyc, pc, instr, err, e, dat_of(e));
                end
                e = e + 32'd4;
            end
            @(posedge clk); #2;
            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = $urandom();
            ready       = ($urandom_range(0, 3) != 0);
            resp_en     = ($urandom_range(0, 3) != 0);
        end
        redirect = 1'b0; stall_rand = 1'b0; resp_en = 1'b1;
        tests_run++;
        if (pops < 500) begin
            tests_failed++;
            $display("FAIL random_progress: got %0d pops want at least 500", pops);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] p, ins;
        logic        er, ok;
        ready = 1'b1; resp_en = 1'b1; stall_rand = 1'b0; err_at = -1;
        apply_reset();
        repeat (5) @(negedge clk);
        tests_run++;
        if ({valid, wb_cyc} !== 2'b11) begin
            tests_failed++;
            $display("FAIL async_pre: got valid=%b cyc=%b want 1 1", valid, wb_cyc);
        end
        #1 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({wb_cyc, wb_stb, valid, err, idle} !== 5'b00001) begin
            tests_failed++;
            $display("FAIL async_reset: got cyc/stb/valid/err/idle=%b want 00001",
                     {wb_cyc, wb_stb, valid, err, idle});
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests_run++;
        if ({wb_stb, wb_adr} !== {1'b1, INIT}) begin
            tests_failed++;
            $display("FAIL async_restart_stb: got stb=%b adr=%h want 1 %h", wb_stb, wb_adr, INIT);
        end
        wait_pop(p, ins, er, ok);
        tests_run++;
        if ({ok, p, ins} !== {1'b1, INIT, dat_of(INIT)}) begin
            tests_failed++;
            $display("FAIL async_restart_pop: got ok=%b pc=%h instr=%h want 1 %h %h",
                     ok, p, ins, INIT, dat_of(INIT));
        end
    endtask

    initial begin
        rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; ready = 1'b0;
        resp_en = 1'b1; stall_rand = 1'b0; err_at = -1;
        test_reset();
        test_stream();
        test_full();
        test_redirect();
        test_error();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
